q_matrix_ctrl: RTL and testbench
================================

# q_matrix_ctrl

Sequencer that drives the 3×3 rotation-matrix (Q) generator. It accepts three sin/cos angle pairs from an upstream angle source (CORDIC stage) over a valid/ready stream, and loads them into the Q generator. It then triggers the matrix computation and reads the nine elements out in row-major order into a local buffer. Finally it streams those elements downstream with row/column tags and a last marker. The block sits between the angle pipeline and the matrix-inverse datapath, which consumes Q.

## Interface
- SIZE, 16, signed fixed-point word width of sin, cos and Q (Q4.12 at default)
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  angle beat valid
- in_ready  out  1  angle beat accepted when in_valid & in_ready
- in_sin, in_cos  in  SIZE  signed angle pair; beat k (0..2) is angle k
- qm_load  out  1  load strobe to Q generator
- qm_addr  out  2  angle index for qm_load
- qm_sin, qm_cos  out  SIZE  registered copy of the accepted beat
- qm_start  out  1  one-cycle compute pulse
- qm_read  out  1  element read enable
- qm_done  in  1  compute complete, level
- qm_finish  in  1  ninth element presented
- qm_q  in  SIZE  element presented by Q generator, valid the cycle after a read cycle
- out_valid  out  1  element valid
- out_ready  in  1  downstream accept
- out_q  out  SIZE  element
- out_row, out_col  out  2  element position, 0..2
- out_last  out  1  high with element (2,2)
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error, cleared only by reset

## Operation
- States: IDLE, LOAD, START, WAIT_DONE, READ, DRAIN.
- IDLE:
  - in_ready=0.
  - Goes to LOAD when in_valid=1. The beat is not accepted in that cycle.
- LOAD:
  - in_ready=1. A 2-bit beat counter runs 0..2.
  - Each accepted beat k registers qm_load=1, qm_addr=k, qm_sin/qm_cos=beat for exactly one cycle.
  - After beat 2's load cycle: go to START, and in_ready drops.
- START:
  - qm_start=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - On qm_done=1, go to READ.
- READ:
  - qm_read=1 for exactly 9 consecutive cycles.
  - qm_q is captured on the cycle after each read cycle into buffer entry 0..8, in row-major order.
  - On the 9th capture, qm_finish must be 1; otherwise set err. Either way, go to DRAIN.
- DRAIN:
  - out_valid=1 and out_q/out_row/out_col come from buffer entry idx. Advance idx on out_valid & out_ready.
  - out_last=1 at idx 8. A handshake at idx 8 returns to IDLE.
  - out_* hold stable while out_ready=0.
- qm_load, qm_start and qm_read are mutually exclusive, never high together.
- No new angles are accepted until DRAIN completes.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0. Buffer contents are not reset.
- Let E be the edge accepting beat 2.
  - qm_load is high in cycle E..E+1.
  - qm_start is high in E+1..E+2.
  - qm_read goes high after E+3 and is sampled on edges E+4..E+12.
  - Captures occur on edges E+5..E+13.
  - out_valid first rises after E+13, i.e. 13 cycles from the last accept, with no stall.
- With out_ready held 1, DRAIN takes 9 cycles. in_ready can rise 2 cycles after the last handshake (via IDLE).
- in_valid low mid-LOAD: hold with the beat counter unchanged.
- Asynchronous reset mid-operation:
  - All outputs drop immediately; the next operation restarts at beat 0.
  - Any partial load in the Q generator is overwritten by the next LOAD sequence.
- qm_finish seen high before the 9th capture: ignored.
- err is sticky and does not stall the flow.

## Configuration
- Q_CTRL_TIMEOUT_EN defined:
  - A 5-bit watchdog counts cycles in WAIT_DONE.
  - If qm_done is still 0 after 16 cycles, set err and go to IDLE with no DRAIN.
- Not defined: WAIT_DONE waits indefinitely and there is no watchdog logic.

## Structure
- Package q_ctrl_pkg holds:
  - the state enum q_ctrl_state_t;
  - localparams NUM_ANGLES=3, NUM_ELEMS=9, WD_LIMIT=16;
  - the row/col decode function for indices 0..8.
- One sub-module, q_result_buf: a 9×SIZE register file with one write port (capture index) and one asynchronous read port (drain index).
- The FSM, counters and handshake logic live in q_matrix_ctrl.

## Test plan
- Nominal:
  - Stimulus: three beats sin/cos = (0x0000,0x1000), (0x0800,0x0DDB), (0xF800,0x0DDB), with a Q-generator model.
  - Required: loads at addr 0,1,2; one start pulse; 9 reads; 9 outputs in row-major order matching the model; out_last only on (2,2); first out_valid 13 cycles after the last accept.
- Backpressure:
  - Stimulus: out_ready toggling 1,0,0,1 repeatedly.
  - Required: out_* stable while stalled; exactly 9 handshakes, no drops or repeats.
- Gapped input:
  - Stimulus: in_valid low for 5 cycles between beats 1 and 2.
  - Required: no extra qm_load; correct addresses; identical outputs.
- Missing finish:
  - Stimulus: model withholds qm_finish.
  - Required: err=1 after the 9th capture; 9 elements still drained; err stays 1 until reset.
- Reset mid-READ:
  - Stimulus: assert rst_n=0 at the 4th read, then issue a new triplet.
  - Required: outputs 0 immediately; the new triplet completes normally with correct data.
- Q_CTRL_TIMEOUT_EN:
  - Stimulus: qm_done held 0.
  - Required: err=1 and busy=0 16 cycles after entering WAIT_DONE; out_valid never rises.

Source files
------------

// File: rtl/q_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | q_ctrl_pkg : shared types, sizes and helpers for q_matrix_ctrl     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package q_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        READ      = 3'd4,
        DRAIN     = 3'd5
    } q_ctrl_state_t;

    localparam int NUM_ANGLES = 3;
    localparam int NUM_ELEMS  = 9;
    localparam int WD_LIMIT   = 16;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } q_pos_t;

    // Row-major element index to (row, col).
    function automatic q_pos_t elem_pos(input logic [3:0] idx);
        q_pos_t p;
        p = '0;
        case (idx)
            4'd0: p = {2'd0, 2'd0};
            4'd1: p = {2'd0, 2'd1};
            4'd2: p = {2'd0, 2'd2};
            4'd3: p = {2'd1, 2'd0};
            4'd4: p = {2'd1, 2'd1};
            4'd5: p = {2'd1, 2'd2};
            4'd6: p = {2'd2, 2'd0};
            4'd7: p = {2'd2, 2'd1};
            4'd8: p = {2'd2, 2'd2};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_result_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | q_result_buf : 9-entry element buffer, one write, one async read   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module q_result_buf
    import q_ctrl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [3:0]      wr_idx,
    input  logic [SIZE-1:0] wr_data,
    input  logic [3:0]      rd_idx,
    output logic [SIZE-1:0] rd_data
);

    logic [SIZE-1:0] mem_q [NUM_ELEMS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/q_matrix_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | q_matrix_ctrl : load angles, run Q generator, buffer and stream Q  |
// | Option: Q_CTRL_TIMEOUT_EN adds a WAIT_DONE watchdog.  Rev 1.0       |
// +--------------------------------------------------------------------+
module q_matrix_ctrl
    import q_ctrl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SIZE-1:0] in_sin,
    input  logic signed [SIZE-1:0] in_cos,
    output logic                   qm_load,
    output logic [1:0]             qm_addr,
    output logic signed [SIZE-1:0] qm_sin,
    output logic signed [SIZE-1:0] qm_cos,
    output logic                   qm_start,
    output logic                   qm_read,
    input  logic                   qm_done,
    input  logic                   qm_finish,
    input  logic signed [SIZE-1:0] qm_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SIZE-1:0] out_q,
    output logic [1:0]             out_row,
    output logic [1:0]             out_col,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_ELEMS - 1);
    localparam logic [1:0] LAST_BEAT = 2'(NUM_ANGLES - 1);

    q_ctrl_state_t   state_q, state_d;
    logic [1:0]      beat_cnt_q, beat_cnt_d;
    logic [3:0]      rd_cnt_q, rd_cnt_d;
    logic [3:0]      cap_cnt_q, cap_cnt_d;
    logic [3:0]      drain_idx_q, drain_idx_d;
    logic            cap_en_q, cap_en_d;
    logic            qm_load_q, qm_load_d;
    logic            qm_start_q, qm_start_d;
    logic            err_q, err_d;
    logic [1:0]      qm_addr_q, qm_addr_d;
    logic [SIZE-1:0] qm_sin_q, qm_sin_d;
    logic [SIZE-1:0] qm_cos_q, qm_cos_d;
    logic            buf_we;
    logic [SIZE-1:0] buf_rdata;
    q_pos_t          pos;
`ifdef Q_CTRL_TIMEOUT_EN
    logic [4:0]      wd_cnt_q, wd_cnt_d;
`endif

    assign in_ready  = (state_q == LOAD);
    assign qm_read   = (state_q == READ) && (rd_cnt_q <= LAST_IDX);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign pos       = elem_pos(drain_idx_q);
    // Gate the buffer read so nothing unreset leaks onto out_* outside DRAIN.
    assign out_q     = out_valid ? buf_rdata : '0;
    assign out_row   = out_valid ? pos.row : 2'd0;
    assign out_col   = out_valid ? pos.col : 2'd0;
    assign out_last  = out_valid && (drain_idx_q == LAST_IDX);

    assign qm_load   = qm_load_q;
    assign qm_addr   = qm_addr_q;
    assign qm_sin    = qm_sin_q;
    assign qm_cos    = qm_cos_q;
    assign qm_start  = qm_start_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        drain_idx_d = drain_idx_q;
        cap_en_d    = 1'b0;
        qm_load_d   = 1'b0;
        qm_start_d  = 1'b0;
        qm_addr_d   = qm_addr_q;
        qm_sin_d    = qm_sin_q;
        qm_cos_d    = qm_cos_q;
        err_d       = err_q;
        buf_we      = 1'b0;
`ifdef Q_CTRL_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                beat_cnt_d = 2'd0;
                if (in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    qm_load_d = 1'b1;
                    qm_addr_d = beat_cnt_q;
                    qm_sin_d  = in_sin;
                    qm_cos_d  = in_cos;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = 2'd0;
                        state_d    = START;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            START: begin
                qm_start_d = 1'b1;
                rd_cnt_d   = 4'd0;
                cap_cnt_d  = 4'd0;
`ifdef Q_CTRL_TIMEOUT_EN
                wd_cnt_d   = 5'd0;
`endif
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (qm_done) begin
                    state_d = READ;
                end
`ifdef Q_CTRL_TIMEOUT_EN
                else if (wd_cnt_q == 5'(WD_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 5'd1;
                end
`endif
            end
            READ: begin
                if (qm_read) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
                // Element for a read is presented one cycle later.
                cap_en_d = qm_read;
                if (cap_en_q) begin
                    buf_we    = 1'b1;
                    cap_cnt_d = cap_cnt_q + 4'd1;
                    if (cap_cnt_q == LAST_IDX) begin
                        if (!qm_finish) begin
                            err_d = 1'b1;
                        end
                        drain_idx_d = 4'd0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drain_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        drain_idx_d = drain_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= 2'd0;
            rd_cnt_q    <= 4'd0;
            cap_cnt_q   <= 4'd0;
            drain_idx_q <= 4'd0;
            cap_en_q    <= 1'b0;
            qm_load_q   <= 1'b0;
            qm_start_q  <= 1'b0;
            qm_addr_q   <= 2'd0;
            qm_sin_q    <= '0;
            qm_cos_q    <= '0;
            err_q       <= 1'b0;
`ifdef Q_CTRL_TIMEOUT_EN
            wd_cnt_q    <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            drain_idx_q <= drain_idx_d;
            cap_en_q    <= cap_en_d;
            qm_load_q   <= qm_load_d;
            qm_start_q  <= qm_start_d;
            qm_addr_q   <= qm_addr_d;
            qm_sin_q    <= qm_sin_d;
            qm_cos_q    <= qm_cos_d;
            err_q       <= err_d;
`ifdef Q_CTRL_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    q_result_buf #(
        .SIZE (SIZE)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (cap_cnt_q),
        .wr_data (qm_q),
        .rd_idx  (drain_idx_q),
        .rd_data (buf_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_q_matrix_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_q_matrix_ctrl : directed bench with a behavioural Q generator   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_q_matrix_ctrl;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] in_sin = '0;
    logic [SIZE-1:0] in_cos = '0;
    logic            qm_load;
    logic [1:0]      qm_addr;
    logic [SIZE-1:0] qm_sin, qm_cos;
    logic            qm_start, qm_read;
    logic            qm_done = 1'b0;
    logic            qm_finish = 1'b0;
    logic [SIZE-1:0] qm_q = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] out_q;
    logic [1:0]      out_row, out_col;
    logic            out_last, busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    q_matrix_ctrl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sin    (in_sin),
        .in_cos    (in_cos),
        .qm_load   (qm_load),
        .qm_addr   (qm_addr),
        .qm_sin    (qm_sin),
        .qm_cos    (qm_cos),
        .qm_start  (qm_start),
        .qm_read   (qm_read),
        .qm_done   (qm_done),
        .qm_finish (qm_finish),
        .qm_q      (qm_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus triplet for the current operation; the bench derives expected Q from it.
    logic [15:0] exp_s [3];
    logic [15:0] exp_c [3];

    function automatic logic [15:0] exp_elem(input int i);
        return exp_s[i/3] + exp_c[i%3] + 16'(i);
    endfunction

    // Behavioural Q generator: element i = sin[row] + cos[col] + i.
    logic [15:0] ms [4];
    logic [15:0] mc [4];
    int  ridx = 0;
    bit  withhold = 1'b0;
    bit  no_done  = 1'b0;

    function automatic logic [15:0] model_elem(input int i);
        return ms[i/3] + mc[i%3] + 16'(i);
    endfunction

    always @(posedge clk) begin
        if (qm_load) begin
            ms[qm_addr] <= qm_sin;
            mc[qm_addr] <= qm_cos;
            qm_done     <= 1'b0;
        end
        if (qm_start) begin
            qm_done <= !no_done;
            ridx    <= 0;
        end
        qm_finish <= 1'b0;
        if (qm_read) begin
            qm_q      <= model_elem(ridx);
            qm_finish <= (ridx == 8) && !withhold;
            ridx      <= ridx + 1;
        end
    end

    // Downstream: always ready, or the 1,0,0,1 pattern.
    bit bp_mode = 1'b0;
    int bp_phase = 0;
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ((bp_phase == 0) || (bp_phase == 3)) : 1'b1;
        bp_phase  = (bp_phase + 1) % 4;
    end

    // Monitors sample on the falling edge.
    int          load_cnt = 0, start_cnt = 0, read_cnt = 0, hs_cnt = 0;
    int          excl_viol = 0, stall_viol = 0, ov_rise_cnt = 0;
    int          last_acc_cyc = 0, ov_rise_cyc = 0;
    logic [1:0]  ld_addr [64];
    logic [31:0] ld_data [64];
    logic [15:0] hs_q    [256];
    logic [4:0]  hs_pos  [256];
    bit          ov_prev = 1'b0, stall_prev = 1'b0;
    logic [20:0] stall_val = '0;

    always @(negedge clk) begin
        if (qm_load) begin
            ld_addr[load_cnt % 64] = qm_addr;
            ld_data[load_cnt % 64] = {qm_sin, qm_cos};
            load_cnt++;
        end
        if (qm_start) start_cnt++;
        if (qm_read)  read_cnt++;
        if (int'(qm_load) + int'(qm_start) + int'(qm_read) > 1) excl_viol++;
        if (in_valid && in_ready) last_acc_cyc = cyc;
        if (out_valid && !ov_prev) begin
            ov_rise_cyc = cyc;
            ov_rise_cnt++;
        end
        ov_prev = out_valid;
        if (stall_prev && out_valid && ({out_q, out_row, out_col, out_last} != stall_val)) stall_viol++;
        stall_prev = out_valid && !out_ready;
        stall_val  = {out_q, out_row, out_col, out_last};
        if (out_valid && out_ready) begin
            hs_q[hs_cnt % 256]   = out_q;
            hs_pos[hs_cnt % 256] = {out_row, out_col, out_last};
            hs_cnt++;
        end
    end

    task automatic send_beat(input logic [15:0] s, input logic [15:0] c);
        int n;
        in_valid = 1'b1;
        in_sin   = s;
        in_cos   = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_triplet(input int gap);
        send_beat(exp_s[0], exp_c[0]);
        send_beat(exp_s[1], exp_c[1]);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        send_beat(exp_s[2], exp_c[2]);
    endtask

    task automatic run_op(input int gap);
        int hb, lb, sb, rb, n;
        @(posedge clk);
        #1;
        hb = hs_cnt; lb = load_cnt; sb = start_cnt; rb = read_cnt;
        send_triplet(gap);
        n = 0;
        while ((hs_cnt - hb) < 9 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("handshakes", hs_cnt - hb, 9);
        check("loads", load_cnt - lb, 3);
        check("starts", start_cnt - sb, 1);
        check("reads", read_cnt - rb, 9);
        for (int k = 0; k < 3; k++) begin
            check("load_addr", ld_addr[(lb + k) % 64], k);
            check("load_data", ld_data[(lb + k) % 64], {exp_s[k], exp_c[k]});
        end
        for (int i = 0; i < 9; i++) begin
            check("out_q", hs_q[(hb + i) % 256], exp_elem(i));
            check("out_pos", hs_pos[(hb + i) % 256], {2'(i / 3), 2'(i % 3), (i == 8)});
        end
        // Accepting negedge to first out_valid negedge: 13 cycles after the edge, 14 samples.
        check("latency", ov_rise_cyc - last_acc_cyc, 14);
        check("busy_end", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_set_a();
        exp_s[0] = 16'h0000; exp_c[0] = 16'h1000;
        exp_s[1] = 16'h0800; exp_c[1] = 16'h0DDB;
        exp_s[2] = 16'hF800; exp_c[2] = 16'h0DDB;
    endtask

    initial begin
        int nr, n, ovb;
        load_set_a();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_strobes", {qm_load, qm_start, qm_read}, 0);
        check("rst_qm_bus", {qm_addr, qm_sin, qm_cos}, 0);
        check("rst_out_bus", {out_q, out_row, out_col, out_last}, 0);
        rst_n = 1'b1;

        // Nominal
        run_op(0);
        check("err_nominal", err, 0);

        // Backpressure
        bp_mode = 1'b1;
        run_op(0);
        check("stall_stable", stall_viol, 0);
        bp_mode = 1'b0;

        // Gapped input
        run_op(5);

        // Missing finish, then sticky err through a clean operation
        withhold = 1'b1;
        run_op(0);
        check("err_no_finish", err, 1);
        withhold = 1'b0;
        run_op(0);
        check("err_sticky", err, 1);
        do_reset();
        check("err_cleared", err, 0);

        // Reset during the 4th read, then a fresh triplet
        @(posedge clk);
        #1;
        send_triplet(0);
        nr = 0; n = 0;
        while (nr < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (qm_read) nr++;
        end
        check("mid_read_reached", nr, 4);
        #1 rst_n = 1'b0;
        #1;
        check("mr_strobes", {qm_load, qm_start, qm_read}, 0);
        check("mr_busy", busy, 0);
        check("mr_out", {out_valid, out_q, out_row, out_col, out_last}, 0);
        check("mr_in_ready", in_ready, 0);
        check("mr_qm_bus", {qm_addr, qm_sin, qm_cos}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_s[0] = 16'h0400; exp_c[0] = 16'h0F80;
        exp_s[1] = 16'h0C00; exp_c[1] = 16'h0B50;
        exp_s[2] = 16'hF000; exp_c[2] = 16'h0A00;
        run_op(0);
        check("err_after_restart", err, 0);

        // qm_done never arrives
        no_done = 1'b1;
        load_set_a();
        @(posedge clk);
        #1;
        ovb = ov_rise_cnt;
        send_triplet(0);
`ifdef Q_CTRL_TIMEOUT_EN
        n = 0;
        while (!qm_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wd_start_seen", qm_start, 1);
        repeat (15) @(negedge clk);
        check("wd_busy_before", busy, 1);
        @(negedge clk);
        check("wd_busy_after", busy, 0);
        check("wd_err", err, 1);
        repeat (5) @(negedge clk);
        check("wd_no_drain", ov_rise_cnt - ovb, 0);
`else
        repeat (40) @(negedge clk);
        check("nowd_busy", busy, 1);
        check("nowd_err", err, 0);
        check("nowd_no_drain", ov_rise_cnt - ovb, 0);
`endif
        no_done = 1'b0;
        do_reset();

        check("strobes_exclusive", excl_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
